// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed scanner for a common-anode, multi-digit 7-segment display.
// A packed multi-digit hex value is double-buffered: writes land in a pending
// shadow and are copied to the active copy only on the last cycle of a frame.
// A frame is one full pass over every digit, so the display never shows a mix
// of old and new digits.
// Each digit gets a slot of REFRESH_DIV cycles. The first BLANK_CYCLES cycles
// of every slot keep all anodes off, so the previous digit's segments cannot
// ghost onto the next one. During blanking the nibble output already carries
// the new digit, which gives the external decoder time to settle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   value_in     packed digits, nibble i = bits [4i+3:4i], digit 0 rightmost
//   load         capture value_in / dp_in this cycle
//   dp_in        decimal point per digit, active-high
//   digit_en     per-digit enable, 0 = never lit (used live, not buffered)
//   lz_en        leading-zero suppression enable (used live)
//   hex          nibble for the current slot, to the hex-to-segment decoder
//   an_n         digit anodes, active-low, at most one low at a time
//   dp_n         decimal point, active-low
//   frame_start  one-cycle pulse on the first cycle of a new frame
//
// All outputs are registered. The value after edge k is computed from the
// slot position and active data held just before edge k, so no input reaches
// an output combinationally.
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // -------------------------------------------------------------------------
  // Scan position: cycle-in-slot counter and digit index
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             cnt_wrap;
  logic             boundary;

  assign cnt_wrap = (cnt_reg == CNT_LAST);
  // Last cycle of the last slot: the only cycle where the active data changes.
  assign boundary = cnt_wrap && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    idx_next = idx_reg;
    if (cnt_wrap) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Double buffer: pending shadow plus the active copy that is displayed
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
  logic [NUM_DIGITS-1:0]   pending_dp_reg, pending_dp_next;
  logic                    pend_v_reg, pend_v_next;
  logic [4*NUM_DIGITS-1:0] active_reg, active_next;
  logic [NUM_DIGITS-1:0]   active_dp_reg, active_dp_next;

  always_comb begin
    pending_next    = pending_reg;
    pending_dp_next = pending_dp_reg;
    pend_v_next     = pend_v_reg;
    active_next     = active_reg;
    active_dp_next  = active_dp_reg;

    if (boundary) begin
      if (load) begin
        // A load on the boundary bypasses the shadow entirely. Clearing
        // pend_v stops an older pending value from being applied one frame
        // later on top of this newer one.
        active_next    = value_in;
        active_dp_next = dp_in;
        pend_v_next    = 1'b0;
      end else if (pend_v_reg) begin
        active_next    = pending_reg;
        active_dp_next = pending_dp_reg;
        pend_v_next    = 1'b0;
      end
    end else if (load) begin
      // Later loads in the same frame simply overwrite the shadow.
      pending_next    = value_in;
      pending_dp_next = dp_in;
      pend_v_next     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      pending_dp_reg <= '0;
      pend_v_reg     <= 1'b0;
      active_reg     <= '0;
      active_dp_reg  <= '0;
    end else begin
      pending_reg    <= pending_next;
      pending_dp_reg <= pending_dp_next;
      pend_v_reg     <= pend_v_next;
      active_reg     <= active_next;
      active_dp_reg  <= active_dp_next;
    end
  end

  // -------------------------------------------------------------------------
  // Per-digit views of the active data
  //   nib[i]         active nibble of digit i
  //   upper_clear[i] digits i..NUM_DIGITS-1 are all zero and carry no decimal
  //                  point. This is the leading-zero condition for digit i.
  //                  It is built as a chain from the most significant digit
  //                  down to digit 0.
  // -------------------------------------------------------------------------
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_clear;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic digit_clear;

      assign nib[gi]     = active_reg[4*gi +: 4];
      assign digit_clear = (nib[gi] == 4'h0) && !active_dp_reg[gi];

      if (gi == NUM_DIGITS - 1) begin : g_top
        assign upper_clear[gi] = digit_clear;
      end else begin : g_chain
        assign upper_clear[gi] = digit_clear && upper_clear[gi+1];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output decode for the current slot
  // -------------------------------------------------------------------------
  logic                  show_phase;
  logic                  lz_blank;
  logic                  lit;
  logic [3:0]            hex_next;
  logic [NUM_DIGITS-1:0] an_n_next;
  logic                  dp_n_next;
  logic                  frame_start_next;

  assign show_phase = (cnt_reg >= CNT_SHOW);
  // Digit 0 is never blanked, so a value of all zeros still shows "0".
  assign lz_blank   = lz_en && (idx_reg != '0) && upper_clear[idx_reg];
  assign lit        = show_phase && digit_en[idx_reg] && !lz_blank;

  always_comb begin
    hex_next         = nib[idx_reg];
    an_n_next        = '1;
    dp_n_next        = 1'b1;
    frame_start_next = boundary;
    if (lit) begin
      an_n_next[idx_reg] = 1'b0;
      dp_n_next          = !active_dp_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex         <= 4'h0;
      an_n        <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hex         <= hex_next;
      an_n        <= an_n_next;
      dp_n        <= dp_n_next;
      frame_start <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
//
// Directed and randomized stimulus for seg7_scan_mux (4 digits, 8-cycle
// slots, 2 blank cycles). Expected outputs come from a timeline model: the
// slot position is derived from the number of clock edges since reset. The
// displayed value is tracked as whole integers (active, pending, valid flag).
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value_in;
  logic          load;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          lz_en;
  logic [3:0]    hex;
  logic [3:0]    an_n;
  logic          dp_n;
  logic          frame_start;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_edge;     // clock edges since reset release
  logic [15:0] m_active;
  logic [3:0]  m_adp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_pv;

  seg7_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .hex        (hex),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_edge   = 0;
    m_active = '0;
    m_adp    = '0;
    m_pend   = '0;
    m_pdp    = '0;
    m_pv     = 1'b0;
  endtask

  task automatic check_outputs(input logic [3:0] e_hex, input logic [3:0] e_an,
                               input logic e_dp, input logic e_fs, input string tag);
    tests += 4;
    assert (hex === e_hex) else begin
      fails++;
      $error("FAIL %s hex: got %h expected %h (edge %0d)", tag, hex, e_hex, m_edge);
    end
    assert (an_n === e_an) else begin
      fails++;
      $error("FAIL %s an_n: got %b expected %b (edge %0d)", tag, an_n, e_an, m_edge);
    end
    assert (dp_n === e_dp) else begin
      fails++;
      $error("FAIL %s dp_n: got %b expected %b (edge %0d)", tag, dp_n, e_dp, m_edge);
    end
    assert (frame_start === e_fs) else begin
      fails++;
      $error("FAIL %s frame_start: got %b expected %b (edge %0d)", tag, frame_start, e_fs, m_edge);
    end
  endtask

  // One clock edge: predict the outputs from the inputs present at the edge,
  // check them 1 time unit later, then advance the model.
  task automatic step(input string tag);
    logic [3:0] e_hex;
    logic [3:0] e_an;
    logic       e_dp;
    logic       e_fs;
    logic [3:0] one;
    logic       lz;
    logic       lit;
    logic       bnd;
    int         cnt;
    int         idx;
    @(posedge clk);
    one = 4'b0001;
    if (!rst_n) begin
      e_hex = 4'h0;
      e_an  = 4'hF;
      e_dp  = 1'b1;
      e_fs  = 1'b0;
      bnd   = 1'b0;
    end else begin
      cnt   = m_edge % DIV;
      idx   = (m_edge / DIV) % ND;
      bnd   = (m_edge % FRAME) == FRAME - 1;
      e_hex = 4'((m_active >> (4 * idx)) & 16'h000F);
      lz    = lz_en && idx > 0 && ((m_active >> (4 * idx)) == 16'h0) && ((m_adp >> idx) == 4'h0);
      lit   = cnt >= BLK && digit_en[idx] && !lz;
      e_an  = lit ? ~(one << idx) : 4'hF;
      e_dp  = !(lit && m_adp[idx]);
      e_fs  = bnd;
      if (load) begin
        if (bnd) begin
          m_active = value_in;
          m_adp    = dp_in;
          m_pv     = 1'b0;
        end else begin
          m_pend = value_in;
          m_pdp  = dp_in;
          m_pv   = 1'b1;
        end
      end else if (bnd && m_pv) begin
        m_active = m_pend;
        m_adp    = m_pdp;
        m_pv     = 1'b0;
      end
      m_edge++;
    end
    #1;
    check_outputs(e_hex, e_an, e_dp, e_fs, tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  // Single-cycle load pulse, issued right after an edge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input string tag);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    $display("[TB] load value=%h dp=%b at edge %0d", v, d, m_edge);
    step(tag);
    load     = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    value_in = '0;
    load     = 1'b0;
    dp_in    = '0;
    digit_en = 4'hF;
    lz_en    = 1'b0;
    model_reset();

    // 1: reset values while held, then free-running scan
    run(3, "reset");
    rst_n = 1'b1;
    run(2 * FRAME + 8, "scan");

    // 2: shadow load mid-frame, applied at the next boundary
    for (int k = 0; k < FRAME && (m_edge % FRAME) != 5; k++) step("align2");
    do_load(16'h1234, 4'b0100, "load1234");
    run(2 * FRAME + 4, "show1234");

    // 3: leading-zero suppression, then cancelled by a decimal point
    lz_en = 1'b1;
    do_load(16'h0050, 4'b0000, "lz");
    run(2 * FRAME, "lz");
    do_load(16'h0050, 4'b1000, "lzdp");
    run(2 * FRAME, "lzdp");

    // 4: per-digit enables
    lz_en    = 1'b0;
    digit_en = 4'b1010;
    do_load(16'h8888, 4'b1111, "den");
    run(2 * FRAME, "den");
    digit_en = 4'hF;

    // 5: load exactly on the boundary cycle, with a stale pending value queued
    do_load(16'h7777, 4'b0001, "stale");
    for (int k = 0; k < FRAME && (m_edge % FRAME) != FRAME - 1; k++) step("align5");
    do_load(16'hABCD, 4'b0000, "bnd");
    run(3 * FRAME, "bnd");

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        value_in = 16'($urandom);
        if ($urandom_range(0, 1) == 0) value_in[15:8] = 8'h00;
        dp_in    = 4'($urandom);
        if ($urandom_range(0, 1) == 0) dp_in = 4'h0;
        load     = 1'b1;
        $display("[TB] load value=%h dp=%b at edge %0d", value_in, dp_in, m_edge);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom);
      step("rand");
    end
    load     = 1'b0;
    digit_en = 4'hF;
    lz_en    = 1'b0;
    do_load(16'h9999, 4'b0100, "pre6");
    run(FRAME, "pre6");

    // 6: asynchronous reset in the SHOW phase of digit 2
    for (int k = 0; k < FRAME && (m_edge % FRAME) != 2 * DIV + 4; k++) step("align6");
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs(4'h0, 4'hF, 1'b1, 1'b0, "async_rst");
    model_reset();
    run(2, "in_rst");
    rst_n = 1'b1;
    run(FRAME + 4, "resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
